// File: rtl/vga_fb_arbiter_pkg.sv
// Shared VGA constants, arbiter state encoding and RGB332 helpers used by the
// timing generator and the framebuffer arbiter.
package vga_fb_arbiter_pkg;

  localparam int VGA_H_ACTIVE    = 640;
  localparam int VGA_V_ACTIVE    = 480;
  localparam int VGA_SCALE_SHIFT = 2;
  localparam int VGA_FB_W        = VGA_H_ACTIVE >> VGA_SCALE_SHIFT;
  localparam int VGA_ADDR_W      = 15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DISP = 2'd1;
  localparam logic [1:0] ST_WR0  = 2'd2;
  localparam logic [1:0] ST_WR1  = 2'd3;

  // RGB332 field positions: rrr_ggg_bb
  localparam int RGB_R_LSB = 5;
  localparam int RGB_G_LSB = 2;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb888_t;

  function automatic rgb888_t rgb332_expand(input logic [7:0] pix);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = pix[RGB_R_LSB +: 3];
    g = pix[RGB_G_LSB +: 3];
    b = pix[RGB_B_LSB +: 2];
    rgb332_expand.red   = {r, r, r[2:1]};
    rgb332_expand.green = {g, g, g[2:1]};
    rgb332_expand.blue  = {4{b}};
  endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Single-port framebuffer with synchronous read; shaped to infer block RAM.
module vga_fb_ram #(
  parameter int DEPTH  = 19200,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: display fetch has absolute priority, two writers share
// the remaining cycles round-robin; fetched RGB332 pixels are expanded to 8:8:8.
module vga_fb_arbiter
  import vga_fb_arbiter_pkg::*;
#(
  parameter int H_ACTIVE    = VGA_H_ACTIVE,
  parameter int V_ACTIVE    = VGA_V_ACTIVE,
  parameter int SCALE_SHIFT = VGA_SCALE_SHIFT,
  parameter int FB_W        = VGA_FB_W,
  parameter int ADDR_W      = VGA_ADDR_W
) (
  input  logic              board_clock,
  input  logic              reset,
  input  logic [9:0]        x_val,
  input  logic [9:0]        y_val,
  input  logic              active,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [7:0]        wr_data0,
  input  logic [7:0]        wr_data1,
  output logic [1:0]        wr_gnt,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue
);

  localparam int FB_H     = V_ACTIVE >> SCALE_SHIFT;
  localparam int FB_DEPTH = FB_W * FB_H;

  logic [1:0]        state;
  logic              fetch;
  logic              last_served;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              ram_we;
  logic              fetch_d1;
  logic              active_d1;
  logic              active_d2;
  logic [7:0]        pixel;
  rgb888_t           rgb;

  assign fetch = active && (x_val[SCALE_SHIFT-1:0] == '0) && (x_val < 10'(H_ACTIVE));
  assign fetch_addr = ADDR_W'(y_val >> SCALE_SHIFT) * ADDR_W'(FB_W)
                    + ADDR_W'(x_val >> SCALE_SHIFT);

  // State is a pure function of this cycle's inputs; reset forces IDLE so a
  // pending grant is dropped the moment reset rises.
  always_comb begin
    state = ST_IDLE;
    if (reset)
      state = ST_IDLE;
    else if (fetch)
      state = ST_DISP;
    else if (wr_req == 2'b11)
      state = last_served ? ST_WR0 : ST_WR1;
    else if (wr_req[0])
      state = ST_WR0;
    else if (wr_req[1])
      state = ST_WR1;
  end

  always_comb begin
    ram_addr  = fetch_addr;
    ram_wdata = wr_data0;
    if (state == ST_WR0) begin
      ram_addr  = wr_addr0;
      ram_wdata = wr_data0;
    end else if (state == ST_WR1) begin
      ram_addr  = wr_addr1;
      ram_wdata = wr_data1;
    end
  end

  assign wr_gnt = {state == ST_WR1, state == ST_WR0};
  // Out-of-range writes still get their grant but never reach the array.
  assign ram_we = (wr_gnt != 2'b00) && (ram_addr < ADDR_W'(FB_DEPTH));

  vga_fb_ram #(
    .DEPTH  (FB_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (board_clock),
    .we    (ram_we),
    .re    (state == ST_DISP),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge board_clock or posedge reset) begin
    if (reset) begin
      last_served <= 1'b1;
      fetch_d1    <= 1'b0;
      active_d1   <= 1'b0;
      active_d2   <= 1'b0;
      pixel       <= '0;
    end else begin
      if (state == ST_WR0)
        last_served <= 1'b0;
      else if (state == ST_WR1)
        last_served <= 1'b1;
      fetch_d1  <= (state == ST_DISP);
      active_d1 <= active;
      active_d2 <= active_d1;
      if (fetch_d1)
        pixel <= ram_rdata;
    end
  end

  assign rgb   = rgb332_expand(pixel);
  assign red   = active_d2 ? rgb.red   : '0;
  assign green = active_d2 ? rgb.green : '0;
  assign blue  = active_d2 ? rgb.blue  : '0;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter: directed stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  x_val = '0;
  logic [9:0]  y_val = '0;
  logic        active = 1'b0;
  logic [1:0]  wr_req = '0;
  logic [14:0] wr_addr0 = '0;
  logic [14:0] wr_addr1 = '0;
  logic [7:0]  wr_data0 = '0;
  logic [7:0]  wr_data1 = '0;
  logic [1:0]  wr_gnt;
  logic [7:0]  red, green, blue;

  vga_fb_arbiter #(
    .H_ACTIVE    (640),
    .V_ACTIVE    (480),
    .SCALE_SHIFT (2),
    .FB_W        (160),
    .ADDR_W      (15)
  ) dut (
    .board_clock (clk),
    .reset       (reset),
    .x_val       (x_val),
    .y_val       (y_val),
    .active      (active),
    .wr_req      (wr_req),
    .wr_addr0    (wr_addr0),
    .wr_addr1    (wr_addr1),
    .wr_data0    (wr_data0),
    .wr_data1    (wr_data1),
    .wr_gnt      (wr_gnt),
    .red         (red),
    .green       (green),
    .blue        (blue)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [1:0] g; } gnt_exp_t;
  typedef struct { int cyc; logic [23:0] rgb; } pix_exp_t;

  gnt_exp_t gq[$];
  pix_exp_t pq[$];
  gnt_exp_t ge;
  pix_exp_t pe;
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (gq.size() != 0 && gq[0].cyc == cyc) begin
      ge = gq.pop_front();
      tests++;
      if (wr_gnt !== ge.g) begin
        fails++;
        $display("FAIL wr_gnt cyc %0d: got %b expected %b", cyc, wr_gnt, ge.g);
      end
    end else if (wr_gnt !== 2'b00) begin
      tests++;
      fails++;
      $display("FAIL unexpected wr_gnt cyc %0d: got %b expected 00", cyc, wr_gnt);
    end
    while (pq.size() != 0 && pq[0].cyc == cyc) begin
      pe = pq.pop_front();
      tests++;
      if ({red, green, blue} !== pe.rgb) begin
        fails++;
        $display("FAIL rgb cyc %0d: got %h_%h_%h expected %h", cyc, red, green, blue, pe.rgb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_gnt(input int c, input logic [1:0] g);
    gq.push_back('{cyc: c, g: g});
  endtask

  task automatic exp_pix(input int c, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pq.push_back('{cyc: c, rgb: {r, g, b}});
  endtask

  // Single write with the display blanked: granted in the same cycle.
  task automatic wr(input int n, input logic [14:0] a, input logic [7:0] d);
    active = 1'b0;
    if (n == 0) begin
      wr_addr0 = a; wr_data0 = d; wr_req = 2'b01; exp_gnt(cyc, 2'b01);
    end else begin
      wr_addr1 = a; wr_data1 = d; wr_req = 2'b10; exp_gnt(cyc, 2'b10);
    end
    step();
    wr_req = 2'b00;
  endtask

  // Display one 4-pixel group starting at x0 and expect colour then blanking.
  task automatic show(input int y, input int x0, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int base;
    base = cyc;
    for (int i = 2; i <= 5; i++) exp_pix(base + i, r, g, b);
    exp_pix(base + 6, 8'h00, 8'h00, 8'h00);
    y_val = 10'(y);
    for (int i = 0; i < 4; i++) begin
      x_val = 10'(x0 + i);
      active = 1'b1;
      step();
    end
    active = 1'b0;
    for (int i = 0; i < 3; i++) step();
  endtask

  initial begin
    int base;
    step();
    step();
    // Requests while held in reset are ignored and outputs stay dark.
    wr_req = 2'b11;
    exp_gnt(cyc, 2'b00);
    exp_pix(cyc, 8'h00, 8'h00, 8'h00);
    step();

    // Contention right after release: writer 0 wins first, then alternate.
    reset = 1'b0;
    wr_addr0 = 15'd100; wr_data0 = 8'h11;
    wr_addr1 = 15'd101; wr_data1 = 8'h22;
    for (int i = 0; i < 4; i++) begin
      exp_gnt(cyc, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
    end
    wr_req = 2'b00;

    wr(0, 15'd0, 8'hE0);
    wr(1, 15'd1, 8'h03);
    wr(0, 15'd487, 8'hFF);
    wr(1, 15'd19199, 8'h1C);
    wr(0, 15'd19200, 8'hFF);

    // Display sweep x=0..7 with writer 0 requesting: no grant in fetch cycles.
    base = cyc;
    for (int i = 2; i <= 5; i++) exp_pix(base + i, 8'hFF, 8'h00, 8'h00);
    for (int i = 6; i <= 9; i++) exp_pix(base + i, 8'h00, 8'h00, 8'hFF);
    exp_pix(base + 10, 8'h00, 8'h00, 8'h00);
    y_val = 10'd0;
    wr_addr0 = 15'd5000; wr_data0 = 8'h77;
    for (int i = 0; i < 8; i++) begin
      x_val = 10'(i);
      active = 1'b1;
      wr_req = 2'b01;
      exp_gnt(cyc, (i % 4 == 0) ? 2'b00 : 2'b01);
      step();
    end
    active = 1'b0;
    wr_req = 2'b00;
    for (int i = 0; i < 3; i++) step();

    show(479, 636, 8'h00, 8'hFF, 8'h00);
    show(13, 28, 8'hFF, 8'hFF, 8'hFF);
    show(0, 400, 8'h00, 8'h92, 8'h55);
    show(0, 404, 8'h24, 8'h00, 8'hAA);
    show(0, 0, 8'hFF, 8'h00, 8'h00);

    // Reset lands in the middle of a writer-1 grant cycle while pixels are lit.
    base = cyc;
    for (int i = 2; i <= 4; i++) exp_pix(base + i, 8'hFF, 8'h00, 8'h00);
    exp_pix(base + 5, 8'h00, 8'h00, 8'h00);
    exp_gnt(base + 5, 2'b00);
    y_val = 10'd0;
    wr_addr1 = 15'd0; wr_data1 = 8'h00;
    for (int i = 0; i < 6; i++) begin
      x_val = 10'(i);
      active = 1'b1;
      if (i == 5) begin
        wr_req = 2'b10;
        #2 reset = 1'b1;
      end
      step();
    end
    active = 1'b0;
    wr_req = 2'b00;
    exp_pix(cyc, 8'h00, 8'h00, 8'h00);
    step();

    reset = 1'b0;
    wr_addr0 = 15'd201; wr_data0 = 8'h33;
    wr_addr1 = 15'd200; wr_data1 = 8'h44;
    wr_req = 2'b11;
    exp_gnt(cyc, 2'b01);
    step();
    exp_gnt(cyc, 2'b10);
    step();
    wr_req = 2'b00;

    show(0, 0, 8'hFF, 8'h00, 8'h00);
    show(4, 160, 8'h49, 8'h24, 8'h00);
    show(4, 164, 8'h24, 8'h92, 8'hFF);

    step();
    step();
    if (gq.size() != 0 || pq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL leftover expectations: got %0d grant %0d pixel, expected 0", gq.size(), pq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000, expected earlier finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameters, one per line:
- H_ACTIVE, 640, visible pixels per line.
- V_ACTIVE, 480, visible lines.
- SCALE_SHIFT, 2, log2 of the pixel replication factor.
- FB_W, 160, framebuffer width (H_ACTIVE>>SCALE_SHIFT).
- ADDR_W, 15, framebuffer address width.
REQ-002 SHALL have these ports:
- board_clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- x_val  in  10  current pixel column from the timing generator.
- y_val  in  10  current pixel row from the timing generator.
- active  in  1  high while (x_val,y_val) is in the visible region.
- wr_req  in  2  per-writer write request; bit n = writer n.
- wr_addr0, wr_addr1  in  ADDR_W  write address per writer.
- wr_data0, wr_data1  in  8  RGB332 write data per writer.
- wr_gnt  out  2  one-cycle pulse when writer n's write commits.
- red, green, blue  out  8  expanded pixel colour.

Function
REQ-003 SHALL own one single-port framebuffer, FB_W*120 x 8 bits, with a registered read of 1 cycle; one access (read or write) per cycle.
REQ-004 A display fetch cycle SHALL occur when active=1 and x_val[1:0]==0; it reads address (y_val>>2)*FB_W + (x_val>>2), computed at ADDR_W width, with no truncation for x<640, y<480.
REQ-005 The display fetch SHALL have absolute priority; no write is granted in a display fetch cycle.
REQ-006 In every non-fetch cycle, at most one writer SHALL be granted, by round-robin through a 1-bit last-served pointer.
- Only one requesting writer: it is granted.
- Both requesting: the writer other than last_served is granted.
REQ-007 FSM states SHALL be:
- DISP: fetch cycle.
- WR0 / WR1: write by that writer.
- IDLE: no access.
REQ-008 The state SHALL be decided combinationally each cycle, and last_served SHALL update only on entering WR0/WR1.
REQ-009 A grant SHALL write wr_dataN to wr_addrN in that cycle and assert wr_gnt[N] for exactly that cycle.
REQ-010 A writer SHALL hold wr_req, address and data stable until its grant; the block SHALL NOT queue requests.
REQ-011 wr_gnt SHALL never have both bits set, and SHALL never be set in a DISP cycle.
REQ-012 Fetched RGB332 data SHALL be latched into a pixel register one cycle after the fetch and held for the 4-pixel group.
REQ-013 Colour outputs SHALL lag x_val by 2 cycles, with `active` delayed to match.
REQ-014 RGB332 expansion SHALL be:
- red = {r[2:0], r[2:0], r[2:1]}
- green = {g[2:0], g[2:0], g[2:1]}
- blue = {b[1:0] replicated 4x}
REQ-015 red/green/blue SHALL be 0 whenever the delayed active flag is 0.
REQ-016 Behaviour at boundaries:
- Writes to addresses >= 19200 SHALL be granted and discarded.
- The row of x_val=636..639 SHALL be fetched normally; no fetch wraps past FB_W-1.
- A write to the address being fetched in the same cycle SHALL NOT occur, because of REQ-005.

Reset
REQ-017 Asserting reset SHALL asynchronously set:
- state to IDLE;
- last_served to 1, so writer 0 wins the first tie;
- wr_gnt to 0;
- the pixel register and delay pipeline to 0;
- red/green/blue to 0.
REQ-018 Framebuffer contents SHALL NOT be cleared by reset.
REQ-019 Reset asserted mid-frame SHALL drop any pending grant without a partial write; the first fetch after release SHALL follow REQ-004 from the current x_val/y_val.

Structure
REQ-020 H_ACTIVE, V_ACTIVE, SCALE_SHIFT, FB_W, ADDR_W, the state encoding and the RGB332 field positions SHALL reside in a shared vga package/include used by the timing generator and this block.
REQ-021 The framebuffer SHALL be one sub-module, vga_fb_ram: single-port, synchronous read, write-enable, mapping to Gowin block RAM.
REQ-022 Arbitration, address generation and colour expansion SHALL remain in vga_fb_arbiter.

Verification
REQ-023 Single writer: wr_req=01, wr_addr0=0, wr_data0=8'hE0, active=0 -> wr_gnt=01 on the next non-fetch cycle. Then active=1, x=0, y=0 -> red=8'hFF, green=0, blue=0 two cycles later, held for 4 pixels.
REQ-024 Contention: wr_req=11 held, active=0, both writers requesting continuously -> wr_gnt alternates 01,10,01,10 after reset; never 11.
REQ-025 Display priority: active=1, x_val stepping 0..7, wr_req=01 -> no grant at x=0 or x=4; grants only at x=1,2,3,5,6,7, gated on the writer reasserting.
REQ-026 Address boundary: write 8'h1C to address 19199, display x=639, y=479 -> green=8'hFF, red=blue=0. A write to address 19200 receives its grant, and memory is unchanged.
REQ-027 Blanking: active=0 with nonzero memory -> red/green/blue=0 within 2 cycles.
REQ-028 Reset mid-operation: assert reset during a WR1 cycle -> wr_gnt=0 and RGB=0 immediately; after release, both requesting -> writer 0 is granted first; previously written data is still readable.
